// File: rtl/ram_arbiter_pkg.sv
// Shared types for the RAM arbiter: data word, strobe, port ids and response owner.
package ram_arbiter_pkg;

    localparam int XLEN                   = 32;
    localparam int STRB_W                 = XLEN / 8;
    localparam int DEFAULT_RAM_ADDR_WIDTH = 12;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [STRB_W-1:0] strobe_t;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_LSU    = 1'b1
    } ram_port_e;

    typedef enum logic [1:0] {
        RSP_NONE = 2'b00,
        RSP_P0   = 2'b01,
        RSP_P1   = 2'b10
    } rsp_owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Purpose: 2-way round-robin grant core with a port-1 lock for read-modify-write.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: a loser simply sees gnt low and holds its request.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       lock,
    output logic [1:0] gnt
);

    ram_port_e  prio;
    logic       locked;
    logic [1:0] gnt_raw;

    always_comb begin
        gnt_raw = 2'b00;
        if (locked) begin
            // Port 0 is starved while locked, even if port 1 is idle.
            gnt_raw[1] = req[1];
        end else begin
            case (req)
                2'b01:   gnt_raw = 2'b01;
                2'b10:   gnt_raw = 2'b10;
                2'b11:   gnt_raw = (prio == PORT_LSU) ? 2'b10 : 2'b01;
                default: gnt_raw = 2'b00;
            endcase
        end
        gnt = rst_n ? gnt_raw : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio   <= PORT_LSU;
            locked <= 1'b0;
        end else begin
            if (gnt[0]) begin
                prio <= PORT_LSU;
            end else if (gnt[1]) begin
                prio <= PORT_IFETCH;
            end

            if (!lock) begin
                locked <= 1'b0;
            end else if (gnt[1]) begin
                locked <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Purpose: share one single-port byte-strobed RAM between ifetch (port 0) and LSU (port 1).
// Latency: grant same cycle; read data and rvalid one cycle after a granted read.
// Backpressure: requester holds req and payload stable until its gnt is seen high.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  word_t                 m0_wdata,
    input  strobe_t               m0_strobe,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output word_t                 m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  word_t                 m1_wdata,
    input  strobe_t               m1_strobe,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output word_t                 m1_rdata,

    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output word_t                 ram_wr_data,
    output strobe_t               ram_wr_strobe,
    input  word_t                 ram_rd_data
);

    logic [1:0] gnt;
    logic       rd0;
    logic       rd1;
    rsp_owner_t rsp_owner;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({m1_req, m0_req}),
        .lock  (m1_lock),
        .gnt   (gnt)
    );

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];

    assign rd0 = gnt[0] & ~m0_we;
    assign rd1 = gnt[1] & ~m1_we;

    always_comb begin
        ram_addr      = m1_addr;
        ram_wr_data   = m1_wdata;
        ram_wr_strobe = m1_strobe;
        if (gnt[0]) begin
            ram_addr      = m0_addr;
            ram_wr_data   = m0_wdata;
            ram_wr_strobe = m0_strobe;
        end
        ram_rd_en = rd0 | rd1;
        ram_wr_en = (gnt[0] & m0_we) | (gnt[1] & m1_we);
    end

    // Remembers who issued last cycle's read so the RAM's registered data is steered back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_owner <= RSP_NONE;
        end else if (rd0) begin
            rsp_owner <= RSP_P0;
        end else if (rd1) begin
            rsp_owner <= RSP_P1;
        end else begin
            rsp_owner <= RSP_NONE;
        end
    end

    assign m0_rvalid = (rsp_owner == RSP_P0);
    assign m1_rvalid = (rsp_owner == RSP_P1);
    assign m0_rdata  = ram_rd_data;
    assign m1_rdata  = ram_rd_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1-cycle registered RAM attached.
module tb_ram_arbiter;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata, m0_rdata;
    logic [3:0]    m0_strobe;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;
    logic [3:0]    m1_strobe;
    logic          ram_rd_en, ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wr_data, ram_rd_data;
    logic [3:0]    ram_wr_strobe;

    logic [31:0]   mem [256];
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .m0_req        (m0_req),
        .m0_we         (m0_we),
        .m0_addr       (m0_addr),
        .m0_wdata      (m0_wdata),
        .m0_strobe     (m0_strobe),
        .m0_gnt        (m0_gnt),
        .m0_rvalid     (m0_rvalid),
        .m0_rdata      (m0_rdata),
        .m1_req        (m1_req),
        .m1_we         (m1_we),
        .m1_addr       (m1_addr),
        .m1_wdata      (m1_wdata),
        .m1_strobe     (m1_strobe),
        .m1_lock       (m1_lock),
        .m1_gnt        (m1_gnt),
        .m1_rvalid     (m1_rvalid),
        .m1_rdata      (m1_rdata),
        .ram_rd_en     (ram_rd_en),
        .ram_wr_en     (ram_wr_en),
        .ram_addr      (ram_addr),
        .ram_wr_data   (ram_wr_data),
        .ram_wr_strobe (ram_wr_strobe),
        .ram_rd_data   (ram_rd_data)
    );

    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_wr_strobe[b]) mem[ram_addr][8*b +: 8] <= ram_wr_data[8*b +: 8];
            end
        end
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m0_set(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_strobe = st;
    endtask

    task automatic m1_set(input logic req, input logic we, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input logic [3:0] st);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_strobe = st;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h11] = 32'h0BADF00D;
        mem[8'h40] = 32'h11223344;
        ram_rd_data = 32'h0;

        rst_n = 1'b1;
        m1_lock = 1'b0;
        m0_set(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h11, 32'h0, 4'h0);
        #1 rst_n = 1'b0;
        #3;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);
        repeat (2) @(posedge clk);

        // Single read by port 0
        @(negedge clk);
        rst_n = 1'b1;
        m1_set(1'b0, 1'b0, 8'h11, 32'h0, 4'h0);
        #1;
        chk("rd_m0_gnt", m0_gnt, 1);
        chk("rd_m1_gnt", m1_gnt, 0);
        chk("rd_ram_rd_en", ram_rd_en, 1);
        chk("rd_ram_addr", ram_addr, 8'h10);
        @(negedge clk);
        chk("rd_m0_rvalid", m0_rvalid, 1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rvalid", m1_rvalid, 0);

        // Contention: prio is 1, so grants go 1,0,1,0
        m0_set(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h11, 32'h0, 4'h0);
        #1;
        chk("ct1_m1_gnt", m1_gnt, 1);
        chk("ct1_m0_gnt", m0_gnt, 0);
        chk("ct1_addr", ram_addr, 8'h11);
        @(negedge clk);
        chk("ct1_m1_rvalid", m1_rvalid, 1);
        chk("ct1_m1_rdata", m1_rdata, 32'h0BADF00D);
        chk("ct1_m0_rvalid", m0_rvalid, 0);
        #1;
        chk("ct2_m0_gnt", m0_gnt, 1);
        chk("ct2_m1_gnt", m1_gnt, 0);
        @(negedge clk);
        chk("ct2_m0_rvalid", m0_rvalid, 1);
        chk("ct2_m1_rvalid", m1_rvalid, 0);
        #1;
        chk("ct3_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        chk("ct3_m1_rvalid", m1_rvalid, 1);
        #1;
        chk("ct4_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        chk("ct4_m0_rvalid", m0_rvalid, 1);
        chk("ct4_m0_rdata", m0_rdata, 32'hDEADBEEF);

        // Byte write: lanes 0 and 2 of 0xAABBCCDD over 0x11223344
        m0_set(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b1, 8'h40, 32'hAABBCCDD, 4'b0101);
        #1;
        chk("bw_m1_gnt", m1_gnt, 1);
        chk("bw_wr_en", ram_wr_en, 1);
        chk("bw_rd_en", ram_rd_en, 0);
        chk("bw_strobe", ram_wr_strobe, 4'b0101);
        chk("bw_wdata", ram_wr_data, 32'hAABBCCDD);
        @(negedge clk);
        chk("bw_m1_rvalid", m1_rvalid, 0);
        chk("bw_m0_rvalid", m0_rvalid, 0);
        m1_set(1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
        m0_set(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        #1;
        chk("bwr_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        chk("bwr_m0_rvalid", m0_rvalid, 1);
        chk("bwr_m0_rdata", m0_rdata, 32'h11BB33DD);

        // Zero-strobe write is granted but leaves the word unchanged
        m0_set(1'b1, 1'b1, 8'h40, 32'hFFFFFFFF, 4'b0000);
        #1;
        chk("zs_m0_gnt", m0_gnt, 1);
        chk("zs_wr_en", ram_wr_en, 1);
        @(negedge clk);
        m0_set(1'b0, 1'b0, 8'h40, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h40, 32'h0, 4'h0);
        #1;
        chk("zsr_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        chk("zsr_m1_rvalid", m1_rvalid, 1);
        chk("zsr_m1_rdata", m1_rdata, 32'h11BB33DD);

        // Back-to-back read-after-write
        m1_set(1'b1, 1'b1, 8'h30, 32'h5, 4'hF);
        #1;
        chk("raw_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        m1_set(1'b0, 1'b0, 8'h30, 32'h0, 4'h0);
        m0_set(1'b1, 1'b0, 8'h30, 32'h0, 4'h0);
        #1;
        chk("raw_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        chk("raw_m0_rvalid", m0_rvalid, 1);
        chk("raw_m0_rdata", m0_rdata, 32'h5);

        // Lock: port 1 read + write + idle with lock high, port 0 requesting throughout
        m0_set(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
        m1_lock = 1'b1;
        #1;
        chk("lk1_m1_gnt", m1_gnt, 1);
        chk("lk1_m0_gnt", m0_gnt, 0);
        @(negedge clk);
        chk("lk1_m1_rvalid", m1_rvalid, 1);
        chk("lk1_m1_rdata", m1_rdata, 32'h0);
        m1_set(1'b1, 1'b1, 8'h20, 32'hCAFEF00D, 4'hF);
        #1;
        chk("lk2_m1_gnt", m1_gnt, 1);
        chk("lk2_m0_gnt", m0_gnt, 0);
        @(negedge clk);
        m1_set(1'b0, 1'b0, 8'h20, 32'h0, 4'h0);
        #1;
        chk("lk3_m0_gnt_idle_p1", m0_gnt, 0);
        @(negedge clk);
        m1_lock = 1'b0;
        #1;
        chk("lk4_m0_gnt_drop", m0_gnt, 0);
        @(negedge clk);
        #1;
        chk("lk5_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        chk("lk5_m0_rvalid", m0_rvalid, 1);
        chk("lk5_m0_rdata", m0_rdata, 32'hDEADBEEF);

        // Locked read by port 1 (prio -> 0), then async reset while its response is live
        m0_set(1'b0, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
        m1_lock = 1'b1;
        #1;
        chk("pre_m1_gnt", m1_gnt, 1);
        @(negedge clk);
        chk("pre_m1_rvalid", m1_rvalid, 1);
        chk("pre_m1_rdata", m1_rdata, 32'hCAFEF00D);
        m1_set(1'b0, 1'b0, 8'h20, 32'h0, 4'h0);
        m1_lock = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("ar_m1_rvalid", m1_rvalid, 0);
        m0_set(1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
        m1_set(1'b1, 1'b0, 8'h11, 32'h0, 4'h0);
        #1;
        chk("ar_m0_gnt", m0_gnt, 0);
        chk("ar_m1_gnt", m1_gnt, 0);
        chk("ar_rd_en", ram_rd_en, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_m1_gnt", m1_gnt, 1);
        chk("post_m0_gnt", m0_gnt, 0);
        @(negedge clk);
        chk("post_m1_rvalid", m1_rvalid, 1);
        chk("post_m1_rdata", m1_rdata, 32'h0BADF00D);
        #1;
        chk("post2_m0_gnt", m0_gnt, 1);
        @(negedge clk);
        m0_set(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        m1_set(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
